// File: rtl/sensor_vid_pkg.sv
// Shared types for the sensor-to-AXI4-Stream video stage.
// Beat layout, FIFO entry and capture state encoding.
package sensor_vid_pkg;

    localparam int LANES  = 16;
    localparam int PIX_W  = 12;
    localparam int BEAT_W = LANES * PIX_W;

    typedef struct packed {
        logic [BEAT_W-1:0] data;
        logic              sof;
        logic              eol;
    } beat_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DROP
    } state_t;

endpackage

// File: rtl/sensor_vid_fifo.sv
// Synchronous first-word-fall-through FIFO of video beats.
// The head entry is presented combinationally while not empty.
module sensor_vid_fifo
    import sensor_vid_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  beat_t                    wr_data,
    input  logic                     rd_en,
    output beat_t                    rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    beat_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Pointers and occupancy; a full FIFO still accepts a write paired with a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    // Storage array, written without reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/sensor_vid_axis.sv
// Parallel sensor bus to AXI4-Stream video with ROI crop and overflow drop.
// Optional statistics outputs when SENSOR_VID_AXIS_STATS_EN is defined.
module sensor_vid_axis
    import sensor_vid_pkg::*;
#(
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_W      = 16
) (
    input  logic              px_clk,
    input  logic              px_reset,
    input  logic [BEAT_W-1:0] din,
    input  logic              en_in,
    input  logic              vs_in,
    input  logic [CNT_W-1:0]  crop_x,
    input  logic [CNT_W-1:0]  crop_w,
    input  logic [CNT_W-1:0]  crop_y,
    input  logic [CNT_W-1:0]  crop_h,
    output logic [BEAT_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic              overflow,
    output logic [15:0]       short_line_cnt
`ifdef SENSOR_VID_AXIS_STATS_EN
    ,
    output logic [31:0]       frame_cnt,
    output logic [15:0]       line_cnt,
    output logic [15:0]       drop_frame_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t            state;
    logic              vs_d;
    logic              en_d;
    logic [CNT_W-1:0]  x;
    logic [CNT_W-1:0]  y;
    logic [CNT_W-1:0]  cx;
    logic [CNT_W-1:0]  cy;
    logic [CNT_W:0]    x_end;
    logic [CNT_W:0]    y_end;
    logic              sof_pend;
    logic              hold_v;
    logic              hold_sof;
    logic              hold_end;
    logic [BEAT_W-1:0] hold_data;
    logic              vs_rise;
    logic              line_end;
    logic              in_win;
    logic              at_end;
    logic              cap;
    logic              ovf_now;
    logic              wr_en;
    logic              rd_en;
    logic              full;
    logic              empty;
    logic [AW:0]       count;
    logic [AW:0]       count_nx;
    beat_t             wr_beat;
    beat_t             head;

    assign vs_rise  = vs_in && !vs_d;
    assign line_end = en_d && !en_in;
    assign in_win   = en_in && (x >= cx) && ({1'b0, x} < x_end)
                    && (y >= cy) && ({1'b0, y} < y_end);
    assign at_end   = (({1'b0, x} + (CNT_W+1)'(1)) == x_end);
    assign cap      = (state == RUN) && !vs_rise && in_win;

    assign rd_en    = m_axis_tvalid && m_axis_tready;
    assign wr_en    = hold_v && (!full || rd_en);
    assign count_nx = count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    // A kept beat is only taken if the hold register is sure to drain next cycle.
    assign ovf_now  = cap && (count_nx == (AW+1)'(FIFO_DEPTH));

    // Hold beat with its line end resolved from the current cycle.
    always_comb begin
        wr_beat      = '0;
        wr_beat.data = hold_data;
        wr_beat.sof  = hold_sof;
        wr_beat.eol  = hold_end || !en_in || vs_rise || ovf_now;
    end

    // Input edge history and beat/line position within the frame.
    always_ff @(posedge px_clk) begin
        if (px_reset) begin
            vs_d <= 1'b0;
            en_d <= 1'b0;
            x    <= '0;
            y    <= '0;
        end else begin
            vs_d <= vs_in;
            en_d <= en_in;
            if (vs_rise) begin
                x <= '0;
                y <= '0;
            end else if (en_in) begin
                x <= x + CNT_W'(1);
            end else if (line_end) begin
                x <= '0;
                if (y != '1) y <= y + CNT_W'(1);
            end
        end
    end

    // Frame control: crop shadowing, SOF tracking and capture/drop state.
    always_ff @(posedge px_clk) begin
        if (px_reset) begin
            state    <= IDLE;
            sof_pend <= 1'b0;
            overflow <= 1'b0;
            cx       <= '0;
            cy       <= '0;
            x_end    <= '0;
            y_end    <= '0;
        end else if (vs_rise) begin
            state    <= RUN;
            sof_pend <= 1'b1;
            cx       <= crop_x;
            cy       <= crop_y;
            x_end    <= {1'b0, crop_x} + {1'b0, crop_w};
            y_end    <= {1'b0, crop_y} + {1'b0, crop_h};
        end else if (ovf_now) begin
            state    <= DROP;
            overflow <= 1'b1;
        end else if (cap) begin
            sof_pend <= 1'b0;
        end
    end

    // One-beat hold so the line end can be seen before the FIFO write.
    always_ff @(posedge px_clk) begin
        if (px_reset) begin
            hold_v    <= 1'b0;
            hold_sof  <= 1'b0;
            hold_end  <= 1'b0;
            hold_data <= '0;
        end else begin
            hold_v    <= cap && !ovf_now;
            hold_sof  <= sof_pend;
            hold_end  <= at_end;
            hold_data <= din;
        end
    end

    // Saturating count of lines that stop before the crop end.
    always_ff @(posedge px_clk) begin
        if (px_reset) begin
            short_line_cnt <= '0;
        end else if (hold_v && !en_in && !hold_end && short_line_cnt != '1) begin
            short_line_cnt <= short_line_cnt + 16'd1;
        end
    end

    sensor_vid_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (px_clk),
        .rst     (px_reset),
        .wr_en   (wr_en),
        .wr_data (wr_beat),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? '0 : head.data;
    assign m_axis_tuser  = !empty && head.sof;
    assign m_axis_tlast  = !empty && head.eol;

`ifdef SENSOR_VID_AXIS_STATS_EN
    logic [15:0] lines_in_frame;

    // Frame, per-frame line and dropped-frame statistics.
    always_ff @(posedge px_clk) begin
        if (px_reset) begin
            frame_cnt      <= '0;
            line_cnt       <= '0;
            drop_frame_cnt <= '0;
            lines_in_frame <= '0;
        end else begin
            if (vs_rise) begin
                frame_cnt      <= frame_cnt + 32'd1;
                line_cnt       <= lines_in_frame;
                lines_in_frame <= '0;
            end else if (line_end) begin
                lines_in_frame <= lines_in_frame + 16'd1;
            end
            if (ovf_now) drop_frame_cnt <= drop_frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sensor_vid_axis.sv
// Bench for sensor_vid_axis: random frames against a per-frame crop model.
// Directed cases cover crop, short line, overflow drop and mid-frame reset.
module tb_sensor_vid_axis;

    typedef struct {
        logic [191:0] d;
        logic         u;
        logic         l;
    } exp_t;

    logic         clk = 1'b0;
    logic         px_reset;
    logic [191:0] din;
    logic         en_in;
    logic         vs_in;
    logic [15:0]  crop_x;
    logic [15:0]  crop_w;
    logic [15:0]  crop_y;
    logic [15:0]  crop_h;
    logic [191:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic         m_axis_tuser;
    logic         m_axis_tlast;
    logic         overflow;
    logic [15:0]  short_line_cnt;
`ifdef SENSOR_VID_AXIS_STATS_EN
    logic [31:0]  frame_cnt;
    logic [15:0]  line_cnt;
    logic [15:0]  drop_frame_cnt;
`endif

    exp_t         expq[$];
    int           n_chk = 0;
    int           n_pass = 0;
    int           rdy_mode = 0;
    int           sl_exp = 0;
    int           rl[8];
    logic [191:0] bt[8][16];

    sensor_vid_axis #(
        .FIFO_DEPTH     (4),
        .CNT_W          (16)
    ) dut (
        .px_clk         (clk),
        .px_reset       (px_reset),
        .din            (din),
        .en_in          (en_in),
        .vs_in          (vs_in),
        .crop_x         (crop_x),
        .crop_w         (crop_w),
        .crop_y         (crop_y),
        .crop_h         (crop_h),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .overflow       (overflow),
        .short_line_cnt (short_line_cnt)
`ifdef SENSOR_VID_AXIS_STATS_EN
        ,
        .frame_cnt      (frame_cnt),
        .line_cnt       (line_cnt),
        .drop_frame_cnt (drop_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [191:0] obs,
                       input logic [191:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [191:0] rnd_beat();
        logic [191:0] v;
        for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ready pattern: 0 stalled, 1 always ready, otherwise random.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    // Scoreboard: every accepted output beat must match the model queue.
    always @(negedge clk) begin
        exp_t e;
        if (!px_reset && m_axis_tvalid && m_axis_tready) begin
            if (expq.size() == 0) begin
                chk("unexpected_beat", 192'(m_axis_tvalid), 192'd0);
            end else begin
                e = expq.pop_front();
                chk("tdata", m_axis_tdata, e.d);
                chk("tuser", 192'(m_axis_tuser), 192'(e.u));
                chk("tlast", 192'(m_axis_tlast), 192'(e.l));
            end
        end
    end

    task automatic send_frame(input bit with_vs, input bit model, input int nl,
                              input int lens[8], input int mid_cx);
        int cx, cw, cy, ch;
        bit first;
        exp_t e;
        cx = int'(crop_x);
        cw = int'(crop_w);
        cy = int'(crop_y);
        ch = int'(crop_h);
        for (int l = 0; l < nl; l++)
            for (int x = 0; x < lens[l]; x++) bt[l][x] = rnd_beat();
        if (model) begin
            first = 1'b1;
            for (int l = 0; l < nl; l++) begin
                for (int x = 0; x < lens[l]; x++) begin
                    if (x >= cx && x < cx + cw && l >= cy && l < cy + ch) begin
                        e.d = bt[l][x];
                        e.u = first;
                        e.l = (x == cx + cw - 1) || (x == lens[l] - 1);
                        first = 1'b0;
                        expq.push_back(e);
                    end
                end
                if (l >= cy && l < cy + ch && lens[l] > cx && lens[l] < cx + cw)
                    sl_exp++;
            end
        end
        if (with_vs) begin
            vs_in = 1'b1;
            tick();
            tick();
            vs_in = 1'b0;
            tick();
        end
        for (int l = 0; l < nl; l++) begin
            for (int x = 0; x < lens[l]; x++) begin
                en_in = 1'b1;
                din   = bt[l][x];
                tick();
            end
            en_in = 1'b0;
            din   = '0;
            tick();
            tick();
            if (l == 0 && mid_cx >= 0) crop_x = 16'(mid_cx);
        end
        repeat (3) tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        chk(tag, 192'(expq.size()), 192'd0);
        repeat (2) tick();
        chk({tag, "_idle"}, 192'(m_axis_tvalid), 192'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        px_reset = 1'b1;
        din      = '0;
        en_in    = 1'b0;
        vs_in    = 1'b0;
        crop_x   = '0;
        crop_w   = '0;
        crop_y   = '0;
        crop_h   = '0;
        repeat (3) tick();
        px_reset = 1'b0;
        tick();

        chk("rst_tvalid", 192'(m_axis_tvalid), 192'd0);
        chk("rst_tdata", m_axis_tdata, 192'd0);
        chk("rst_tuser", 192'(m_axis_tuser), 192'd0);
        chk("rst_tlast", 192'(m_axis_tlast), 192'd0);
        chk("rst_overflow", 192'(overflow), 192'd0);
        chk("rst_short", 192'(short_line_cnt), 192'd0);

        rdy_mode = 1;
        crop_x = 16'd0; crop_w = 16'd4; crop_y = 16'd0; crop_h = 16'd3;
        send_frame(1'b1, 1'b1, 3, '{4, 4, 4, 0, 0, 0, 0, 0}, -1);
        drain("full_frame");

        crop_x = 16'd2; crop_w = 16'd3; crop_y = 16'd1; crop_h = 16'd2;
        send_frame(1'b1, 1'b1, 6, '{8, 8, 8, 8, 8, 8, 0, 0}, -1);
        drain("crop_window");

        crop_x = 16'd0; crop_w = 16'd6; crop_y = 16'd0; crop_h = 16'd1;
        send_frame(1'b1, 1'b1, 1, '{4, 0, 0, 0, 0, 0, 0, 0}, -1);
        drain("short_line");
        chk("short_line_cnt", 192'(short_line_cnt), 192'(sl_exp));

        crop_x = 16'd0; crop_w = 16'd4; crop_y = 16'd0; crop_h = 16'd2;
        send_frame(1'b1, 1'b1, 2, '{6, 6, 0, 0, 0, 0, 0, 0}, 2);
        drain("crop_old");
        send_frame(1'b1, 1'b1, 2, '{6, 6, 0, 0, 0, 0, 0, 0}, -1);
        drain("crop_new");

        for (int f = 0; f < 12; f++) begin
            int nl;
            crop_x = 16'($urandom_range(0, 5));
            crop_w = 16'($urandom_range(0, 5));
            crop_y = 16'($urandom_range(0, 3));
            crop_h = 16'($urandom_range(0, 3));
            nl = int'($urandom_range(1, 6));
            for (int l = 0; l < 8; l++) rl[l] = int'($urandom_range(1, 12));
            rdy_mode = (int'(crop_w) * int'(crop_h) <= 4) ? 2 : 1;
            send_frame(1'b1, 1'b1, nl, rl, -1);
            drain("rand_frame");
            chk("rand_short_cnt", 192'(short_line_cnt), 192'(sl_exp));
        end
        chk("no_overflow_yet", 192'(overflow), 192'd0);

        rdy_mode = 0;
        tick();
        crop_x = 16'd0; crop_w = 16'd10; crop_y = 16'd0; crop_h = 16'd1;
        send_frame(1'b1, 1'b0, 1, '{10, 0, 0, 0, 0, 0, 0, 0}, -1);
        for (int i = 0; i < 4; i++) begin
            e.d = bt[0][i];
            e.u = (i == 0);
            e.l = (i == 3);
            expq.push_back(e);
        end
        chk("ovf_flag", 192'(overflow), 192'd1);
        send_frame(1'b0, 1'b0, 2, '{6, 6, 0, 0, 0, 0, 0, 0}, -1);
        rdy_mode = 1;
        drain("ovf_drain");
        crop_x = 16'd0; crop_w = 16'd4; crop_y = 16'd0; crop_h = 16'd2;
        send_frame(1'b1, 1'b1, 2, '{4, 4, 0, 0, 0, 0, 0, 0}, -1);
        drain("after_ovf");
        chk("ovf_sticky", 192'(overflow), 192'd1);

        rdy_mode = 0;
        tick();
        crop_x = 16'd0; crop_w = 16'd3; crop_y = 16'd0; crop_h = 16'd1;
        send_frame(1'b1, 1'b1, 1, '{3, 0, 0, 0, 0, 0, 0, 0}, -1);
        chk("rst_fifo_loaded", 192'(m_axis_tvalid), 192'd1);
        px_reset = 1'b1;
        tick();
        px_reset = 1'b0;
        expq.delete();
        sl_exp = 0;
        @(negedge clk);
        chk("midrst_tvalid", 192'(m_axis_tvalid), 192'd0);
        chk("midrst_overflow", 192'(overflow), 192'd0);
        chk("midrst_short", 192'(short_line_cnt), 192'd0);
        tick();
        rdy_mode = 1;
        send_frame(1'b0, 1'b0, 2, '{5, 5, 0, 0, 0, 0, 0, 0}, -1);
        chk("midrst_no_out", 192'(m_axis_tvalid), 192'd0);
        crop_x = 16'd1; crop_w = 16'd3; crop_y = 16'd0; crop_h = 16'd2;
        send_frame(1'b1, 1'b1, 2, '{5, 5, 0, 0, 0, 0, 0, 0}, -1);
        drain("midrst_resume");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sensor_vid_axis.md
Name: sensor_vid_axis

Overview:
- Downstream stage of the sensor receiver. Consumes the 16-lane x 12-bit parallel pixel bus (data, line-enable, frame-sync) on px_clk.
- Applies a beat-granular ROI crop and emits AXI4-Stream video: tuser marks SOF, tlast marks EOL.
- The sensor cannot be stalled, so a small FIFO absorbs downstream backpressure. On overflow, the rest of the frame is dropped cleanly and the block resynchronises at the next frame.

Parameters:
- LANES, 16, pixels per beat.
- PIX_W, 12, bits per pixel; data width is LANES*PIX_W = 192.
- FIFO_DEPTH, 64, output FIFO depth in beats; must be a power of two and at least 4.
- CNT_W, 16, width of the crop and position counters.

Ports:
- px_clk  in  1  pixel clock; the only clock.
- px_reset  in  1  synchronous, active-high reset.
- din  in  192  pixel beat; lane k occupies bits [12k+11:12k].
- en_in  in  1  beat valid. A contiguous high run is one line.
- vs_in  in  1  frame sync. A rising edge starts a frame.
- crop_x  in  CNT_W  first beat index kept in each line.
- crop_w  in  CNT_W  beats kept per line; 0 disables output.
- crop_y  in  CNT_W  first line kept.
- crop_h  in  CNT_W  lines kept; 0 disables output.
- m_axis_tdata  out  192  output beat.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.
- m_axis_tuser  out  1  first beat of a frame.
- m_axis_tlast  out  1  last beat of a line.
- overflow  out  1  sticky FIFO-overflow flag; cleared only by px_reset.
- short_line_cnt  out  16  count of lines that ended before the crop end; saturating.

Behaviour:
- Reset: all outputs are 0, the FIFO is empty, all counters are 0, and the state is IDLE.
- Clock and reset: a single clock, px_clk. Reset is synchronous and active-high on px_reset.
- Frame start: the vs_in rising edge is detected with a 1-cycle registered compare. On that edge:
  - crop_x/w/y/h are latched into shadow registers; mid-frame changes have no effect.
  - x and y are cleared.
  - The SOF-pending flag is set.
- Counting: x increments on each en_in beat. On the en_in falling edge, x clears and y increments (saturating at all-ones).
- Window test: a beat is kept when crop_x <= x < crop_x+crop_w and crop_y <= y < crop_y+crop_h. The sums are computed at CNT_W+1 bits, so the window end never wraps.
- Hold register: kept beats go through a 1-beat hold register before the FIFO write, so tlast can be resolved:
  - tlast = 1 if the beat is at x == crop_x+crop_w-1.
  - tlast = 1 if the next cycle shows en_in low (short line). In that case short_line_cnt increments.
- SOF: tuser is set on the first kept beat after the SOF-pending flag is set; writing that beat clears the flag.
- Latency: din to FIFO write is 2 cycles. An empty FIFO adds 1 further cycle to m_axis_tvalid.
- State machine:
  - IDLE -> RUN on a vs_in rise.
  - RUN: normal capture.
  - RUN -> DROP when a write is attempted while the FIFO is full. That beat is lost and overflow is set. If there is a line in flight, the beat already in the hold register is written with tlast forced to 1 once space exists.
  - DROP: discards all beats.
  - DROP -> RUN on the next vs_in rise.
  - A vs_in rise while in RUN restarts the frame. A pending hold beat is written with tlast=1 first.
- FIFO read: combinational from the FIFO head, AXIS compliant. tvalid is held until tready, and tdata/tuser/tlast are stable while tvalid && !tready.
- FIFO full/empty:
  - A simultaneous read and write when full is accepted, with no overflow.
  - A simultaneous read and write when empty passes the beat through next cycle.
- crop_w == 0 or crop_h == 0: no beats are written and no SOF is emitted.
- px_reset mid-frame: the FIFO is flushed immediately and the state returns to IDLE. Output resumes at the next vs_in rise.

Optional Feature:
- Macro: SENSOR_VID_AXIS_STATS_EN.
- When defined, adds these outputs:
  - frame_cnt[31:0]: increments on each vs_in rise.
  - line_cnt[15:0]: lines seen in the last complete frame, latched at the vs_in rise.
  - drop_frame_cnt[15:0]: frames that entered DROP.
  - All are wrapping counters reset by px_reset.
- When undefined, these ports and registers do not exist. Core behaviour is identical either way.

Decomposition:
- Package sensor_vid_pkg holds:
  - constants LANES=16, PIX_W=12, BEAT_W=192.
  - typedef beat_t = struct of data[191:0], sof, eol; this is the FIFO entry.
  - enum state_t {IDLE, RUN, DROP}.
- Sub-module sensor_vid_fifo: a synchronous FIFO of beat_t, depth FIFO_DEPTH, with full/empty outputs and first-word-fall-through read.

Test Plan:
1. Full-frame pass-through:
   - Stimulus: crop 0/4/0/3, 4-beat lines x 3, tready=1.
   - Expected: 12 beats out; tuser on beat 0 only; tlast on beats 3, 7 and 11; data matches input order.
2. Crop window:
   - Stimulus: 8-beat lines x 6, crop_x=2, w=3, y=1, h=2.
   - Expected: 6 beats out, taken from line 1 beats 2-4 and line 2 beats 2-4; tuser on the first; tlast on beats 2 and 5.
3. Short line:
   - Stimulus: crop_w=6, one line of only 4 beats.
   - Expected: tlast on the 4th beat; short_line_cnt = 1.
4. Backpressure overflow:
   - Stimulus: FIFO_DEPTH=4, tready=0, 10-beat line.
   - Expected: overflow=1; only 4 beats are stored, the last forced to tlast; no further beats until the next vs_in.
   - Then: with tready=1, the next frame outputs normally with tuser.
5. Mid-frame crop change:
   - Stimulus: change crop_x during a frame.
   - Expected: the current frame uses the old crop; the next frame uses the new one.
6. Reset mid-frame:
   - Stimulus: pulse px_reset for 1 cycle with the FIFO holding 3 beats.
   - Expected: the next cycle shows tvalid=0 and overflow=0; nothing is output until a vs_in rise.
